// File: rtl/riscv_alu_mc.sv
`default_nettype none
//==============================================================================
// Module      : riscv_alu_mc
// Description : Multi-cycle ALU with valid/ready handshakes, a multi-cycle
//               multiply and (when RISCV_ALU_DIV_EN is defined) an iterative
//               radix-2 restoring divide/remainder unit.
// Revision    : 1.0 - initial release
//==============================================================================
module riscv_alu_mc #(
    parameter int XLEN        = 32,
    parameter int MUL_LATENCY = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            alu_valid_i,
    output logic            alu_ready_o,
    input  logic [3:0]      alu_op_i,
    input  logic [XLEN-1:0] alu_a_i,
    input  logic [XLEN-1:0] alu_b_i,
    output logic            alu_valid_o,
    input  logic            alu_ready_i,
    output logic [XLEN-1:0] alu_p_o
);

    localparam int c_SHW = $clog2(XLEN);
    localparam int c_MCW = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;

    localparam logic [3:0] c_OP_NONE = 4'b0000;
    localparam logic [3:0] c_OP_SLL  = 4'b0001;
    localparam logic [3:0] c_OP_SRL  = 4'b0010;
    localparam logic [3:0] c_OP_SRA  = 4'b0011;
    localparam logic [3:0] c_OP_ADD  = 4'b0100;
    localparam logic [3:0] c_OP_REM  = 4'b0101;
    localparam logic [3:0] c_OP_SUB  = 4'b0110;
    localparam logic [3:0] c_OP_AND  = 4'b0111;
    localparam logic [3:0] c_OP_OR   = 4'b1000;
    localparam logic [3:0] c_OP_XOR  = 4'b1001;
    localparam logic [3:0] c_OP_SLTU = 4'b1010;
    localparam logic [3:0] c_OP_SLT  = 4'b1011;
    localparam logic [3:0] c_OP_MUL  = 4'b1100;
    localparam logic [3:0] c_OP_DIV  = 4'b1101;
    localparam logic [3:0] c_OP_DIVU = 4'b1110;
    localparam logic [3:0] c_OP_REMU = 4'b1111;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_BUSY_MUL = 2'd1,
`ifdef RISCV_ALU_DIV_EN
        S_BUSY_DIV = 2'd3,
`endif
        S_DONE     = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [XLEN-1:0]  r_a;
    logic [XLEN-1:0]  r_b;
    logic [XLEN-1:0]  r_p;
    logic [c_MCW-1:0] r_mul_cnt;
    logic             w_accept;
    logic [XLEN-1:0]  w_res;
    logic [c_SHW-1:0] w_shamt;
    logic [XLEN-1:0]  w_mul_in;
    logic [XLEN-1:0]  w_mul_reg;

    assign alu_ready_o = (r_state == S_IDLE) | ((r_state == S_DONE) & alu_ready_i);
    assign alu_valid_o = (r_state == S_DONE);
    assign alu_p_o     = r_p;
    assign w_accept    = alu_valid_i & alu_ready_o;
    assign w_shamt     = alu_b_i[c_SHW-1:0];
    assign w_mul_in    = alu_a_i * alu_b_i;
    assign w_mul_reg   = r_a * r_b;

`ifdef RISCV_ALU_DIV_EN
    localparam int              c_DCW = $clog2(XLEN);
    localparam logic [XLEN-1:0] c_MIN = {1'b1, {(XLEN-1){1'b0}}};

    logic [3:0]       r_op;
    logic [XLEN-1:0]  r_rem;
    logic [XLEN-1:0]  r_quo;
    logic [XLEN-1:0]  r_dvs;
    logic [c_DCW-1:0] r_div_cnt;
    logic             w_is_div_op;
    logic             w_in_signed;
    logic             w_in_quot;
    logic             w_div_zero;
    logic             w_div_ovf;
    logic             w_div_special;
    logic [XLEN-1:0]  w_div_special_res;
    logic [XLEN-1:0]  w_mag_a;
    logic [XLEN-1:0]  w_mag_b;
    logic             w_r_signed;
    logic             w_r_quot;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [XLEN:0]    w_rem_sh;
    logic [XLEN:0]    w_diff;
    logic [XLEN-1:0]  w_rem_nxt;
    logic [XLEN-1:0]  w_quo_nxt;
    logic [XLEN-1:0]  w_div_res;

    assign w_is_div_op   = (alu_op_i == c_OP_REM) | (alu_op_i == c_OP_DIV) |
                           (alu_op_i == c_OP_DIVU) | (alu_op_i == c_OP_REMU);
    assign w_in_signed   = (alu_op_i == c_OP_DIV) | (alu_op_i == c_OP_REM);
    assign w_in_quot     = (alu_op_i == c_OP_DIV) | (alu_op_i == c_OP_DIVU);
    assign w_div_zero    = (alu_b_i == '0);
    assign w_div_ovf     = w_in_signed & (alu_a_i == c_MIN) & (alu_b_i == '1);
    assign w_div_special = w_div_zero | w_div_ovf;

    always_comb begin
        w_div_special_res = '0;
        if (w_div_zero) begin
            w_div_special_res = w_in_quot ? '1 : alu_a_i;
        end else if (w_div_ovf) begin
            w_div_special_res = w_in_quot ? c_MIN : '0;
        end
    end

    assign w_mag_a = (w_in_signed & alu_a_i[XLEN-1]) ? -alu_a_i : alu_a_i;
    assign w_mag_b = (w_in_signed & alu_b_i[XLEN-1]) ? -alu_b_i : alu_b_i;

    // Extra top bit keeps the shifted partial remainder exact for divisors >= 2^(XLEN-1).
    assign w_r_signed = (r_op == c_OP_DIV) | (r_op == c_OP_REM);
    assign w_r_quot   = (r_op == c_OP_DIV) | (r_op == c_OP_DIVU);
    assign w_a_neg    = w_r_signed & r_a[XLEN-1];
    assign w_b_neg    = w_r_signed & r_b[XLEN-1];
    assign w_rem_sh   = {r_rem, r_quo[XLEN-1]};
    assign w_diff     = w_rem_sh - {1'b0, r_dvs};
    assign w_rem_nxt  = w_diff[XLEN] ? w_rem_sh[XLEN-1:0] : w_diff[XLEN-1:0];
    assign w_quo_nxt  = {r_quo[XLEN-2:0], ~w_diff[XLEN]};
    assign w_div_res  = w_r_quot ? ((w_a_neg ^ w_b_neg) ? -w_quo_nxt : w_quo_nxt)
                                 : (w_a_neg ? -w_rem_nxt : w_rem_nxt);
`endif

    always_comb begin
        w_res = '0;
        case (alu_op_i)
            c_OP_NONE: w_res = '0;
            c_OP_SLL:  w_res = alu_a_i << w_shamt;
            c_OP_SRL:  w_res = alu_a_i >> w_shamt;
            c_OP_SRA:  w_res = $unsigned($signed(alu_a_i) >>> w_shamt);
            c_OP_ADD:  w_res = alu_a_i + alu_b_i;
            c_OP_SUB:  w_res = alu_a_i - alu_b_i;
            c_OP_AND:  w_res = alu_a_i & alu_b_i;
            c_OP_OR:   w_res = alu_a_i | alu_b_i;
            c_OP_XOR:  w_res = alu_a_i ^ alu_b_i;
            c_OP_SLTU: w_res = {{(XLEN-1){1'b0}}, (alu_a_i < alu_b_i)};
            c_OP_SLT:  w_res = {{(XLEN-1){1'b0}}, ($signed(alu_a_i) < $signed(alu_b_i))};
            c_OP_MUL:  w_res = w_mul_in;
`ifdef RISCV_ALU_DIV_EN
            c_OP_REM, c_OP_DIV, c_OP_DIVU, c_OP_REMU: w_res = w_div_special_res;
`else
            c_OP_REM, c_OP_DIV, c_OP_DIVU, c_OP_REMU: w_res = '0;
`endif
            default:   w_res = '0;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_accept) begin
                    if ((alu_op_i == c_OP_MUL) && (MUL_LATENCY > 1)) begin
                        w_state_nxt = S_BUSY_MUL;
`ifdef RISCV_ALU_DIV_EN
                    end else if (w_is_div_op && !w_div_special) begin
                        w_state_nxt = S_BUSY_DIV;
`endif
                    end else begin
                        w_state_nxt = S_DONE;
                    end
                end else if ((r_state == S_DONE) && alu_ready_i) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_BUSY_MUL: begin
                if (r_mul_cnt == c_MCW'(1)) w_state_nxt = S_DONE;
            end
`ifdef RISCV_ALU_DIV_EN
            S_BUSY_DIV: begin
                if (r_div_cnt == '0) w_state_nxt = S_DONE;
            end
`endif
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Accepts only happen in IDLE/DONE, so they never collide with the busy updates.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_a       <= '0;
            r_b       <= '0;
            r_p       <= '0;
            r_mul_cnt <= '0;
`ifdef RISCV_ALU_DIV_EN
            r_op      <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_dvs     <= '0;
            r_div_cnt <= '0;
`endif
        end else begin
            if (w_accept) begin
                r_a       <= alu_a_i;
                r_b       <= alu_b_i;
                r_mul_cnt <= c_MCW'(MUL_LATENCY - 1);
`ifdef RISCV_ALU_DIV_EN
                r_op      <= alu_op_i;
                r_rem     <= '0;
                r_quo     <= w_mag_a;
                r_dvs     <= w_mag_b;
                r_div_cnt <= c_DCW'(XLEN - 1);
`endif
                if (w_state_nxt == S_DONE) r_p <= w_res;
            end
            case (r_state)
                S_BUSY_MUL: begin
                    r_mul_cnt <= r_mul_cnt - 1'b1;
                    if (r_mul_cnt == c_MCW'(1)) r_p <= w_mul_reg;
                end
`ifdef RISCV_ALU_DIV_EN
                S_BUSY_DIV: begin
                    r_rem     <= w_rem_nxt;
                    r_quo     <= w_quo_nxt;
                    r_div_cnt <= r_div_cnt - 1'b1;
                    if (r_div_cnt == '0) r_p <= w_div_res;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_riscv_alu_mc.sv
`default_nettype none
//==============================================================================
// Module      : tb_riscv_alu_mc
// Description : Self-checking bench for riscv_alu_mc against a transaction-level
//               reference model (directed cases plus randomized traffic).
// Revision    : 1.0 - initial release
//==============================================================================
module tb_riscv_alu_mc;

    localparam int XLEN = 32;
    localparam int ML   = 2;

    logic        clk       = 1'b0;
    logic        rst       = 1'b0;
    logic        valid_in  = 1'b0;
    logic        ready_in  = 1'b1;
    logic [3:0]  op_in     = 4'h0;
    logic [31:0] a_in      = '0;
    logic [31:0] b_in      = '0;
    logic        ready_out;
    logic        valid_out;
    logic [31:0] p_out;

    int checks = 0;
    int errors = 0;

    // Reference model state: an in-flight op counts down to its result.
    logic        m_valid = 1'b0;
    logic        m_busy  = 1'b0;
    logic [31:0] m_p     = '0;
    logic [31:0] m_res   = '0;
    int          m_cnt   = 0;

    riscv_alu_mc #(
        .XLEN        (XLEN),
        .MUL_LATENCY (ML)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .alu_valid_i (valid_in),
        .alu_ready_o (ready_out),
        .alu_op_i    (op_in),
        .alu_a_i     (a_in),
        .alu_b_i     (b_in),
        .alu_valid_o (valid_out),
        .alu_ready_i (ready_in),
        .alu_p_o     (p_out)
    );

    always #5 clk = ~clk;

    function automatic logic is_div(input logic [3:0] op);
        return (op == 4'h5) || (op == 4'hD) || (op == 4'hE) || (op == 4'hF);
    endfunction

    function automatic logic [31:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint sa;
        longint sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            4'h1: return a << b[4:0];
            4'h2: return a >> b[4:0];
            4'h3: return 32'(sa >>> b[4:0]);
            4'h4: return a + b;
            4'h6: return a - b;
            4'h7: return a & b;
            4'h8: return a | b;
            4'h9: return a ^ b;
            4'hA: return {31'b0, (a < b)};
            4'hB: return {31'b0, (sa < sb)};
            4'hC: return a * b;
`ifdef RISCV_ALU_DIV_EN
            4'h5, 4'hD, 4'hE, 4'hF: begin
                if (b == 0) return ((op == 4'hD) || (op == 4'hE)) ? 32'hFFFF_FFFF : a;
                if (op == 4'hD) return 32'(sa / sb);
                if (op == 4'h5) return 32'(sa % sb);
                if (op == 4'hE) return a / b;
                return a % b;
            end
`endif
            default: return 32'h0;
        endcase
    endfunction

    function automatic int ref_lat(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op == 4'hC) return ML;
`ifdef RISCV_ALU_DIV_EN
        if (is_div(op) && (b != 0) &&
            !(((op == 4'hD) || (op == 4'h5)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)))
            return XLEN + 1;
`endif
        return 1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_valid = 1'b0;
                m_busy  = 1'b0;
                m_p     = '0;
                m_cnt   = 0;
            end else begin
                logic acc;
                int   lat;
                acc = valid_in && !m_busy && (!m_valid || ready_in);
                if (m_valid && ready_in) m_valid = 1'b0;
                if (m_busy) begin
                    m_cnt--;
                    if (m_cnt == 0) begin
                        m_busy  = 1'b0;
                        m_valid = 1'b1;
                        m_p     = m_res;
                    end
                end
                if (acc) begin
                    lat   = ref_lat(op_in, a_in, b_in);
                    m_res = ref_result(op_in, a_in, b_in);
                    if (lat == 1) begin
                        m_valid = 1'b1;
                        m_p     = m_res;
                    end else begin
                        m_busy = 1'b1;
                        m_cnt  = lat - 1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        check("cmp_valid", 32'(valid_out), 32'(m_valid));
        check("cmp_ready", 32'(ready_out), 32'(!m_busy && (!m_valid || ready_in)));
        if (m_valid) check("cmp_result", p_out, m_p);
    end

    task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_p, input int exp_l);
        int n;
        @(posedge clk); #1;
        valid_in = 1'b1; op_in = op; a_in = a; b_in = b; ready_in = 1'b1;
        #1 check({name, "_rdy"}, 32'(ready_out), 32'd1);
        @(posedge clk); #1;
        valid_in = 1'b0; a_in = $urandom; b_in = $urandom;
        n = 1;
        while (valid_out !== 1'b1 && n < 200) begin
            check({name, "_busy_rdy"}, 32'(ready_out), 32'd0);
            @(posedge clk); #1;
            n++;
        end
        check({name, "_lat"}, 32'(n), 32'(exp_l));
        check({name, "_p"}, p_out, exp_p);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(valid_out), 32'd0);
        check("rst_ready", 32'(ready_out), 32'd1);
        check("rst_p", p_out, 32'h0);
        rst = 1'b0;

        check("model_add", ref_result(4'h4, 32'h7FFF_FFFF, 32'h1), 32'h8000_0000);
        check("model_sra", ref_result(4'h3, 32'h8000_0000, 32'h4), 32'hF800_0000);
        check("model_slt", ref_result(4'hB, 32'hFFFF_FFFF, 32'h1), 32'h1);
        check("model_sltu", ref_result(4'hA, 32'hFFFF_FFFF, 32'h1), 32'h0);
        check("model_mul", ref_result(4'hC, 32'h7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
`ifdef RISCV_ALU_DIV_EN
        check("model_div", ref_result(4'hD, 32'hFFFF_FFF9, 32'h2), 32'hFFFF_FFFD);
        check("model_rem", ref_result(4'h5, 32'hFFFF_FFF9, 32'h2), 32'hFFFF_FFFF);
        check("model_divovf", ref_result(4'hD, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);
`else
        check("model_div", ref_result(4'hD, 32'hFFFF_FFF9, 32'h2), 32'h0);
`endif

        run_op("add_ovf", 4'h4, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1);
        run_op("sra", 4'h3, 32'h8000_0000, 32'h4, 32'hF800_0000, 1);
        run_op("slt", 4'hB, 32'hFFFF_FFFF, 32'h1, 32'h1, 1);
        run_op("sltu", 4'hA, 32'hFFFF_FFFF, 32'h1, 32'h0, 1);
        run_op("none", 4'h0, 32'h1234_5678, 32'h9, 32'h0, 1);
        run_op("mul_big", 4'hC, 32'h0001_0000, 32'h0001_0000, 32'h0, ML);
        run_op("mul_neg", 4'hC, 32'h7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, ML);
`ifdef RISCV_ALU_DIV_EN
        run_op("div", 4'hD, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD, XLEN + 1);
        run_op("rem", 4'h5, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, XLEN + 1);
        run_op("divu", 4'hE, 32'd100, 32'd7, 32'd14, XLEN + 1);
        run_op("remu", 4'hF, 32'd100, 32'd7, 32'd2, XLEN + 1);
        run_op("div_zero", 4'hD, 32'd42, 32'h0, 32'hFFFF_FFFF, 1);
        run_op("remu_zero", 4'hF, 32'd5, 32'h0, 32'd5, 1);
        run_op("div_ovf", 4'hD, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("rem_ovf", 4'h5, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1);
`else
        run_op("div_off", 4'hD, 32'hFFFF_FFF9, 32'h2, 32'h0, 1);
        run_op("rem_off", 4'h5, 32'hFFFF_FFF9, 32'h2, 32'h0, 1);
        run_op("divu_off", 4'hE, 32'd100, 32'd7, 32'h0, 1);
        run_op("remu_zero_off", 4'hF, 32'd5, 32'h0, 32'h0, 1);
`endif

        // Back-pressure: result must hold while the consumer stalls.
        @(posedge clk); #1;
        valid_in = 1'b1; op_in = 4'h4; a_in = 32'd3; b_in = 32'd4; ready_in = 1'b0;
        @(posedge clk); #1;
        valid_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 32'(valid_out), 32'd1);
            check("bp_p", p_out, 32'd7);
            check("bp_ready", 32'(ready_out), 32'd0);
            @(posedge clk); #1;
        end
        valid_in = 1'b1; op_in = 4'h6; a_in = 32'd9; b_in = 32'd2; ready_in = 1'b1;
        #1 check("bp_release_ready", 32'(ready_out), 32'd1);
        @(posedge clk); #1;
        valid_in = 1'b0;
        check("bp_b2b_valid", 32'(valid_out), 32'd1);
        check("bp_b2b_p", p_out, 32'd7);

        // Reset in the middle of a divide.
        @(posedge clk); #1;
        valid_in = 1'b1; op_in = 4'hD; a_in = 32'd1000; b_in = 32'd3; ready_in = 1'b1;
        @(posedge clk); #1;
        valid_in = 1'b0;
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("midrst_valid", 32'(valid_out), 32'd0);
        check("midrst_ready", 32'(ready_out), 32'd1);
        check("midrst_p", p_out, 32'h0);
        @(negedge clk); #1 rst = 1'b0;
        run_op("add_after_rst", 4'h4, 32'd1, 32'd1, 32'd2, 1);

        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            valid_in = 1'($urandom_range(0, 1));
            op_in    = 4'($urandom_range(0, 15));
            a_in     = pick();
            b_in     = pick();
            ready_in = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1;
        valid_in = 1'b0;
        ready_in = 1'b1;
        repeat (XLEN + 8) @(posedge clk);
        #1;
        check("drain_valid", 32'(valid_out), 32'd0);
        check("drain_ready", 32'(ready_out), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
